// File: rtl/serial_deframer.sv
// ============================================================================
// Module      : serial_deframer
// Description : Recovers start/data/stop framed serial bits into parallel
//               words behind a one-entry valid/ready output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_deframer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              serial_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int C_CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;
    logic                w_frame_done;
    logic [DATA_W-1:0]   w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {shift_q[DATA_W-2:0], serial_in};
        end else begin : g_lsb_first
            assign w_shifted = {serial_in, shift_q[DATA_W-1:1]};
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = valid_q;
        ferr_d       = 1'b0;
        ovr_d        = 1'b0;
        w_frame_done = 1'b0;

        if (serial_valid) begin
            case (state_q)
                IDLE: begin
                    if (!serial_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = w_shifted;
                    cnt_d   = cnt_q + C_CNT_W'(1);
                    if (cnt_q == C_CNT_W'(DATA_W - 1)) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // A bad stop bit only ends the frame; it never doubles as a start bit.
                    state_d = IDLE;
                    if (serial_in) begin
                        w_frame_done = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        // A consumer handshake in the same cycle frees the slot for the new word.
        if (w_frame_done) begin
            if (!valid_q || out_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_deframer.sv
// ============================================================================
// Module      : tb_serial_deframer
// Description : Directed self-checking bench for serial_deframer, covering
//               both bit orders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_deframer;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic       serial_valid;
    logic       out_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ferr;
    logic       m_ovr;
    logic [7:0] l_data;
    logic       l_valid;
    logic       l_ferr;
    logic       l_ovr;

    int checks;
    int fails;

    serial_deframer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .data_out     (m_data),
        .out_valid    (m_valid),
        .out_ready    (out_ready),
        .frame_err    (m_ferr),
        .overrun      (m_ovr)
    );

    serial_deframer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .data_out     (l_data),
        .out_valid    (l_valid),
        .out_ready    (out_ready),
        .frame_err    (l_ferr),
        .overrun      (l_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sends start, d[7]..d[0], stop. Returns at the falling edge right after
    // the edge that sampled the stop bit, with serial_valid low.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input bit gap, input bit rdy_stop);
        logic [9:0] bits;
        bits = {1'b0, d, stop_b};
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            serial_in    = bits[i];
            serial_valid = 1'b1;
            if (i == 0 && rdy_stop) out_ready = 1'b1;
            if (gap || i == 0) begin
                @(negedge clk);
                serial_valid = 1'b0;
                if (i == 0 && rdy_stop) out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; serial_in = 1'b1; serial_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checks++;
        if ({m_data, m_valid, m_ferr, m_ovr} !== 11'd0) begin
            fails++; $display("FAIL reset_msb: got %h expected 000", {m_data, m_valid, m_ferr, m_ovr});
        end
        checks++;
        if ({l_data, l_valid, l_ferr, l_ovr} !== 11'd0) begin
            fails++; $display("FAIL reset_lsb: got %h expected 000", {l_data, l_valid, l_ferr, l_ovr});
        end
    endtask

    task automatic test_basic_frame();
        out_ready = 1'b1;
        send_frame(8'hCA, 1'b1, 1'b0, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hCA) begin
            fails++; $display("FAIL basic_data: got v=%b d=%h expected v=1 d=ca", m_valid, m_data);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            fails++; $display("FAIL basic_one_cycle: got v=%b expected v=0", m_valid);
        end
    endtask

    task automatic test_gapped_strobes();
        out_ready = 1'b1;
        send_frame(8'h56, 1'b1, 1'b1, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h56) begin
            fails++; $display("FAIL gapped_data: got v=%b d=%h expected v=1 d=56", m_valid, m_data);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            fails++; $display("FAIL gapped_clear: got v=%b expected v=0", m_valid);
        end
    endtask

    task automatic test_frame_error();
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        checks++;
        if (m_ferr !== 1'b1 || m_valid !== 1'b0 || m_ovr !== 1'b0) begin
            fails++; $display("FAIL ferr_pulse: got ferr=%b v=%b ovr=%b expected 1 0 0", m_ferr, m_valid, m_ovr);
        end
        @(negedge clk);
        checks++;
        if (m_ferr !== 1'b0) begin
            fails++; $display("FAIL ferr_width: got ferr=%b expected 0", m_ferr);
        end
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_ferr !== 1'b0) begin
            fails++; $display("FAIL ferr_recover: got v=%b d=%h ferr=%b expected 1 a5 0", m_valid, m_data, m_ferr);
        end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h11 || m_ovr !== 1'b0) begin
            fails++; $display("FAIL ovr_first: got v=%b d=%h ovr=%b expected 1 11 0", m_valid, m_data, m_ovr);
        end
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        checks++;
        if (m_ovr !== 1'b1 || m_data !== 8'h11 || m_valid !== 1'b1 || m_ferr !== 1'b0) begin
            fails++; $display("FAIL ovr_pulse: got ovr=%b d=%h v=%b ferr=%b expected 1 11 1 0", m_ovr, m_data, m_valid, m_ferr);
        end
        @(negedge clk);
        checks++;
        if (m_ovr !== 1'b0 || m_data !== 8'h11 || m_valid !== 1'b1) begin
            fails++; $display("FAIL ovr_hold: got ovr=%b d=%h v=%b expected 0 11 1", m_ovr, m_data, m_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            fails++; $display("FAIL ovr_drain: got v=%b expected 0", m_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h33) begin
            fails++; $display("FAIL b2b_first: got v=%b d=%h expected 1 33", m_valid, m_data);
        end
        send_frame(8'h44, 1'b1, 1'b0, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h44 || m_ovr !== 1'b0) begin
            fails++; $display("FAIL b2b_swap: got v=%b d=%h ovr=%b expected 1 44 0", m_valid, m_data, m_ovr);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h44) begin
            fails++; $display("FAIL b2b_hold: got v=%b d=%h expected 1 44", m_valid, m_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_drain: got v=%b expected 0", m_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [4:0] partial;
        partial = 5'b01111;
        out_ready = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            @(negedge clk);
            serial_in    = partial[i];
            serial_valid = 1'b1;
        end
        @(negedge clk);
        serial_valid = 1'b0;
        serial_in    = 1'b1;
        rst          = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (m_valid !== 1'b0 || l_valid !== 1'b0) begin
            fails++; $display("FAIL midrst_valid: got msb=%b lsb=%b expected 0 0", m_valid, l_valid);
        end
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h0F || m_ferr !== 1'b0) begin
            fails++; $display("FAIL midrst_msb: got v=%b d=%h ferr=%b expected 1 0f 0", m_valid, m_data, m_ferr);
        end
        checks++;
        if (l_valid !== 1'b1 || l_data !== 8'hF0 || l_ferr !== 1'b0) begin
            fails++; $display("FAIL midrst_lsb: got v=%b d=%h ferr=%b expected 1 f0 0", l_valid, l_data, l_ferr);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || l_valid !== 1'b0) begin
            fails++; $display("FAIL midrst_drain: got msb=%b lsb=%b expected 0 0", m_valid, l_valid);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_basic_frame();
        test_gapped_strobes();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
